// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_ctrl block.
// Holds the controller state encoding and a log2 helper for sizing the clear
// pointer and the internal word address.
package ram_pkg;

    // Controller states: CLEAR sweeps zeros through the array, IDLE serves accesses
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Number of address bits needed to index 'value' words (never less than 1)
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Storage array for ram_ctrl.
// One synchronous write port and one registered read port, no reset on the
// storage or the read register; all access policy lives in ram_ctrl.
module ram_array #(
    parameter int WW    = 8,
    parameter int DEPTH = 512,
    parameter int PW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [WW-1:0] wd,
    input  logic          re,
    input  logic [PW-1:0] raddr,
    output logic [WW-1:0] rd
);

    logic [WW-1:0] mem [DEPTH];

    // Write port: one word per cycle, from either the clear engine or the user
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wd;
        end
    end

    // Read port: the word is captured only on an enabled read and held otherwise
    always_ff @(posedge clk) begin
        if (re) begin
            rd <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM with a controlled access interface.
// Write and read strobes are qualified by cs; reads return one cycle later
// with an rvalid pulse. After reset or a clr pulse a clear engine writes zero
// to every word, one word per cycle, while busy is high and accesses are
// refused. Illegal accesses raise a one-cycle err pulse.
// Optional feature macro: RAM_PARITY_EN adds an even-parity bit per word and
// the par_err output.
module ram_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 512,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          memw,
    input  logic          memr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          clr,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy,
`ifdef RAM_PARITY_EN
    output logic          par_err,
`endif
    output logic          err
);

    import ram_pkg::*;

    // Internal word address width and stored word width
    localparam int PW = clog2(DEPTH);
`ifdef RAM_PARITY_EN
    localparam int WW = DW + 1;
`else
    localparam int WW = DW;
`endif

    // Last word touched by the clear sweep, and DEPTH at the width of {0,addr}
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;

    logic          clearing;
    logic          access;
    logic          oor;
    logic          idle_ok;
    logic          wr_acc;
    logic          rd_acc;
    logic          err_next;

    logic          we;
    logic [PW-1:0] waddr;
    logic [WW-1:0] wd;
    logic [WW-1:0] user_word;
    logic          re;
    logic [WW-1:0] rd_word;
    logic          rd_zero;

    // Access decode: an access is accepted only in IDLE, with no clr competing,
    // with exactly one strobe, and (for writes) inside the array
    always_comb begin
        clearing = (state == CLEAR);
        access   = cs & (memw | memr);
        oor      = ({1'b0, addr} >= DEPTH_W);
        idle_ok  = ~clearing & ~clr & cs;
        wr_acc   = idle_ok & memw & ~memr & ~oor;
        rd_acc   = idle_ok & memr & ~memw;
        err_next = access & (clearing | clr | (memw & memr) | oor);
    end

    // Controller state and clear pointer register; reset always restarts the sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state logic: sweep until the last word is written, restart on clr
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        case (state)
            CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_next = IDLE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + PW'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                ptr_next   = '0;
            end
        endcase
    end

    // Word presented by a user write, with its even-parity bit when enabled
    always_comb begin
`ifdef RAM_PARITY_EN
        user_word = {^wdata, wdata};
`else
        user_word = wdata;
`endif
    end

    // Write-port mux: the clear engine owns the port while clearing
    always_comb begin
        we    = clearing | wr_acc;
        waddr = addr[PW-1:0];
        wd    = user_word;
        if (clearing) begin
            waddr = ptr;
            wd    = '0;
        end
    end

    // Out-of-range reads never touch the array; they return zero instead
    always_comb begin
        re = rd_acc & ~oor;
    end

    ram_array #(
        .WW    (WW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wd    (wd),
        .re    (re),
        .raddr (addr[PW-1:0]),
        .rd    (rd_word)
    );

    // Response strobes, plus a flag that forces rdata to zero after an
    // out-of-range read (also the reset value, so rdata starts at zero)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid  <= 1'b0;
            err     <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            rvalid <= rd_acc;
            err    <= err_next;
            if (rd_acc) begin
                rd_zero <= oor;
            end
        end
    end

    // Visible read data: held between accepted reads by the array read register
    always_comb begin
        rdata = rd_zero ? '0 : rd_word[DW-1:0];
        busy  = clearing;
    end

`ifdef RAM_PARITY_EN
    // Parity check on the returned word: an odd number of ones means corruption
    always_comb begin
        par_err = rvalid & ~rd_zero & (^rd_word);
    end
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed testbench for ram_ctrl with a read-data scoreboard.
// Expected read data is queued when a read is driven and checked when rvalid
// arrives; err, busy timing and held data are checked inline.
// Define RAM_PARITY_EN to also exercise par_err.
module tb_ram_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int AW    = 10;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          cs    = 1'b0;
    logic          memw  = 1'b0;
    logic          memr  = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic          clr   = 1'b0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;
    logic          err;
`ifdef RAM_PARITY_EN
    logic          par_err;
`endif

    int compared   = 0;
    int mismatched = 0;
    int n;

    logic [DW-1:0] exp_q[$];

    ram_ctrl #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .memw   (memw),
        .memr   (memr),
        .addr   (addr),
        .wdata  (wdata),
        .clr    (clr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy),
`ifdef RAM_PARITY_EN
        .par_err(par_err),
`endif
        .err    (err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue any expected read, then check err
    task automatic applyStimulus(input logic c_cs, input logic c_w, input logic c_r,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic c_clr, input logic e_err, input logic e_rv,
                                 input logic [DW-1:0] e_rd, input string tag);
        cs    = c_cs;
        memw  = c_w;
        memr  = c_r;
        addr  = a;
        wdata = d;
        clr   = c_clr;
        if (e_rv) exp_q.push_back(e_rd);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_err"}, 16'(err), 16'(e_err));
        cs   = 1'b0;
        memw = 1'b0;
        memr = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic idleCycle();
        cs   = 1'b0;
        memw = 1'b0;
        memr = 1'b0;
        clr  = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e_err, input string tag);
        applyStimulus(1'b1, 1'b1, 1'b0, a, d, 1'b0, e_err, 1'b0, '0, tag);
    endtask

    task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] e_rd, input logic e_err, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b1, a, '0, 1'b0, e_err, 1'b1, e_rd, tag);
    endtask

    // Count idle cycles until busy drops, bounded so a stuck clear cannot hang
    task automatic waitBusyLow(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 700) begin
            idleCycle();
            cnt++;
        end
    endtask

    // Scoreboard monitor: just after each edge, match rvalid/rdata to the queue
    always @(posedge clk) begin
        logic [DW-1:0] e;
        #1;
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("rvalid_spurious", 16'(rvalid), 16'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("rdata", 16'(rdata), 16'(e));
            end
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("rvalid_missing", 16'(rvalid), 16'(1));
        end
    end

    // Hard time limit
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        $display("[TB] starting ram_ctrl test");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",   16'(busy),   16'(1));
        checkOutput("rst_rvalid", 16'(rvalid), 16'(0));
        checkOutput("rst_err",    16'(err),    16'(0));
        checkOutput("rst_rdata",  16'(rdata),  16'(0));

        // Power-up clear length, then a read of the top word
        rst = 1'b0;
        waitBusyLow(n);
        checkOutput("init_clear_len", 16'(n), 16'(512));
        doRead(10'h1FF, 8'h00, 1'b0, "rd_top");

        // Write then read next cycle, and rdata holding afterwards
        doWrite(10'h003, 8'hA5, 1'b0, "wr_3");
        doRead(10'h003, 8'hA5, 1'b0, "rd_3");
        idleCycle();
        idleCycle();
        checkOutput("rdata_hold", 16'(rdata), 16'hA5);

        // Both strobes at once: error, nothing written or read
        doWrite(10'h010, 8'h3C, 1'b0, "wr_10");
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h010, 8'hFF, 1'b0, 1'b1, 1'b0, '0, "rw_both");
        doRead(10'h010, 8'h3C, 1'b0, "rd_10");

        // Out-of-range accesses
        doRead(10'h200, 8'h00, 1'b1, "rd_oor");
        doWrite(10'h200, 8'h55, 1'b1, "wr_oor");
        doRead(10'h000, 8'h00, 1'b0, "rd_alias0");

        // cs low: strobes ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 10'h005, 8'h77, 1'b0, 1'b0, 1'b0, '0, "cs_low_wr");
        applyStimulus(1'b0, 1'b0, 1'b1, 10'h005, 8'h00, 1'b0, 1'b0, 1'b0, '0, "cs_low_rd");
        doRead(10'h005, 8'h00, 1'b0, "rd_5");

        // Back-to-back reads
        doWrite(10'h020, 8'h01, 1'b0, "wr_20");
        doWrite(10'h021, 8'h02, 1'b0, "wr_21");
        doRead(10'h020, 8'h01, 1'b0, "b2b_20");
        doRead(10'h021, 8'h02, 1'b0, "b2b_21");
        doRead(10'h003, 8'hA5, 1'b0, "b2b_3");
        doRead(10'h1FF, 8'h00, 1'b0, "b2b_1ff");

        // Soft clear with a write attempted at clear cycle 5
        doWrite(10'h000, 8'h99, 1'b0, "wr_0");
        doRead(10'h000, 8'h99, 1'b0, "rd_0_pre");
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, '0, "clr_pulse");
        checkOutput("clr_busy", 16'(busy), 16'(1));
        repeat (4) idleCycle();
        doWrite(10'h000, 8'h11, 1'b1, "wr_in_clear");
        waitBusyLow(n);
        checkOutput("clr_len", 16'(n + 5), 16'(512));
        doRead(10'h000, 8'h00, 1'b0, "rd_0_post");
        doRead(10'h003, 8'h00, 1'b0, "rd_3_post");

        // clr wins over a same-cycle write
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h007, 8'hEE, 1'b1, 1'b1, 1'b0, '0, "clr_vs_wr");
        waitBusyLow(n);
        checkOutput("clr2_len", 16'(n), 16'(512));
        doRead(10'h007, 8'h00, 1'b0, "rd_7");

        // Reset in the middle of a clear restarts the full sweep
        doWrite(10'h004, 8'h5A, 1'b0, "wr_4");
        doRead(10'h004, 8'h5A, 1'b0, "rd_4");
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 1'b0, 1'b0, '0, "clr_pulse2");
        repeat (99) idleCycle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_busy", 16'(busy), 16'(1));
        rst = 1'b0;
        waitBusyLow(n);
        checkOutput("midrst_len", 16'(n), 16'(512));
        doRead(10'h004, 8'h00, 1'b0, "rd_4_post");

`ifdef RAM_PARITY_EN
        // Parity: clean word, then a corrupted stored parity bit
        doWrite(10'h004, 8'h5A, 1'b0, "par_wr_4");
        doRead(10'h004, 8'h5A, 1'b0, "par_rd_ok");
        checkOutput("par_ok", 16'(par_err), 16'(0));
        dut.u_array.mem[4][DW] = ~dut.u_array.mem[4][DW];
        doRead(10'h004, 8'h5A, 1'b0, "par_rd_bad");
        checkOutput("par_flip", 16'(par_err), 16'(1));
`endif

        idleCycle();
        idleCycle();
        checkOutput("queue_drained", 16'(exp_q.size()), 16'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
